// File: rtl/ni_code_gen_if.sv
// Stream bundle for ni_code_gen: neighbour-set input side and NI-code output side.
interface ni_code_gen_if #(
  parameter int PIX_W = 8,
  parameter int N_NB  = 8
);
  logic                    i_valid;
  logic                    o_ready;
  logic [N_NB*PIX_W-1:0]   i_nb;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic [7:0]              o_addr;
  logic                    o_last;

  modport slave (
    input  i_valid, i_nb, i_last, i_ready,
    output o_ready, o_valid, o_addr, o_last
  );

  modport master (
    output i_valid, i_nb, i_last, i_ready,
    input  o_ready, o_valid, o_addr, o_last
  );
endinterface

// File: rtl/ni_code_gen.sv
// Mean-threshold NI code generator feeding the radius-4 NI weight ROM, 3-stage pipe with global stall.
// Build macro NI_MEAN_ROUND_EN selects a round-half-up mean; the default build truncates.
module ni_code_gen #(
  parameter int PIX_W = 8,
  parameter int N_NB  = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  ni_code_gen_if.slave bus
);
  localparam int PSUM_W = PIX_W + 2;
  localparam int SUM_W  = PIX_W + 3;
  localparam int HALF   = N_NB / 2;

  if (N_NB != 8) begin : g_nb_check
    $error("ni_code_gen: N_NB must be 8, the NI code is 8 bits");
  end

  logic                  stall;

  logic                  s1_valid;
  logic                  s1_last;
  logic [N_NB*PIX_W-1:0] s1_nb;
  logic [PSUM_W-1:0]     s1_sum_lo;
  logic [PSUM_W-1:0]     s1_sum_hi;

  logic                  s2_valid;
  logic                  s2_last;
  logic [N_NB*PIX_W-1:0] s2_nb;
  logic [PIX_W-1:0]      s2_mean;

  logic                  s3_valid;
  logic                  s3_last;
  logic [7:0]            s3_addr;

  logic [PSUM_W-1:0]     sum_lo;
  logic [PSUM_W-1:0]     sum_hi;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_adj;
  logic [PIX_W-1:0]      mean;
  logic [7:0]            code;

  // Stall depends only on registered o_valid and downstream ready, so o_ready has no input path.
  assign stall       = s3_valid && !bus.i_ready;
  assign bus.o_ready = !stall;

  always_comb begin
    sum_lo = '0;
    sum_hi = '0;
    for (int k = 0; k < HALF; k++) begin
      sum_lo = sum_lo + PSUM_W'(bus.i_nb[k*PIX_W +: PIX_W]);
      sum_hi = sum_hi + PSUM_W'(bus.i_nb[(k+HALF)*PIX_W +: PIX_W]);
    end
  end

  // Worst case 8*255 + 4 = 2044 still fits in SUM_W bits, so the rounding add cannot wrap.
  always_comb begin
    sum = SUM_W'(s1_sum_lo) + SUM_W'(s1_sum_hi);
`ifdef NI_MEAN_ROUND_EN
    sum_adj = sum + SUM_W'(4);
`else
    sum_adj = sum;
`endif
    mean = PIX_W'(sum_adj >> 3);
  end

  always_comb begin
    code = '0;
    for (int k = 0; k < N_NB; k++) begin
      code[k] = (s2_nb[k*PIX_W +: PIX_W] >= s2_mean);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_nb     <= '0;
      s1_sum_lo <= '0;
      s1_sum_hi <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_nb     <= '0;
      s2_mean   <= '0;
      s3_valid  <= 1'b0;
      s3_last   <= 1'b0;
      s3_addr   <= '0;
    end else if (!stall) begin
      s1_valid  <= bus.i_valid;
      s1_last   <= bus.i_last;
      s1_nb     <= bus.i_nb;
      s1_sum_lo <= sum_lo;
      s1_sum_hi <= sum_hi;

      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_nb     <= s1_nb;
      s2_mean   <= mean;

      // A bubble still clocks through; o_addr's value is meaningless while o_valid is low.
      s3_valid  <= s2_valid;
      s3_last   <= s2_last;
      s3_addr   <= code;
    end
  end

  assign bus.o_valid = s3_valid;
  assign bus.o_last  = s3_last;
  assign bus.o_addr  = s3_addr;
endmodule

// File: tb/tb_ni_code_gen.sv
// Scoreboard bench for ni_code_gen: stimulus pushes expected codes, a negedge monitor pops and compares.
module tb_ni_code_gen;
  localparam int PIX_W = 8;
  localparam int N_NB  = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  ni_code_gen_if #(.PIX_W(PIX_W), .N_NB(N_NB)) bus ();

  ni_code_gen #(.PIX_W(PIX_W), .N_NB(N_NB)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] q[$];
  bit         rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mean of the eight samples by plain integer division, then threshold each sample.
  function automatic logic [8:0] model(input logic [63:0] nb, input logic last);
    int total = 0;
    int mean;
    logic [7:0] code;
    for (int k = 0; k < 8; k++) total += int'(nb[k*8 +: 8]);
`ifdef NI_MEAN_ROUND_EN
    mean = (total + 4) / 8;
`else
    mean = total / 8;
`endif
    for (int k = 0; k < 8; k++) code[k] = (int'(nb[k*8 +: 8]) >= mean);
    return {last, code};
  endfunction

  function automatic logic [63:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (rand_rdy) bus.i_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one set until accepted; expected response is queued at the accepting cycle.
  task automatic send(input logic [63:0] nb, input logic last, input logic [8:0] exp);
    int waited = 0;
    bus.i_valid = 1'b1;
    bus.i_nb    = nb;
    bus.i_last  = last;
    forever begin
      @(negedge i_clk);
      if (bus.o_ready) break;
      tick();
      waited++;
      if (waited > 200) begin
        chk("send_timeout", 32'(bus.o_ready), 32'(1));
        bus.i_valid = 1'b0;
        return;
      end
    end
    q.push_back(exp);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() > 0; i++) tick();
    chk(name, 32'(q.size()), 32'(0));
  endtask

  // Called one tick after the accepting edge: o_valid must rise exactly three cycles after acceptance.
  task automatic latency3(input string name);
    @(negedge i_clk); chk({name, "_c1"}, 32'(bus.o_valid), 32'(0));
    tick();
    @(negedge i_clk); chk({name, "_c2"}, 32'(bus.o_valid), 32'(0));
    tick();
    @(negedge i_clk); chk({name, "_c3"}, 32'(bus.o_valid), 32'(1));
    tick();
  endtask

  initial begin : monitor
    logic [8:0] held = '0;
    bit holding = 1'b0;
    logic [8:0] exp;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        holding = 1'b0;
        continue;
      end
      if (holding) begin
        chk("stall_hold_valid", 32'(bus.o_valid), 32'(1));
        chk("stall_hold_addr", 32'({bus.o_last, bus.o_addr}), 32'(held));
      end
      holding = 1'b0;
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'({bus.o_last, bus.o_addr}), 32'h1FF);
          chk("unexpected_output_valid", 32'(bus.o_valid), 32'(0));
        end else begin
          exp = q.pop_front();
          chk("out_addr", 32'(bus.o_addr), 32'(exp[7:0]));
          chk("out_last", 32'(bus.o_last), 32'(exp[8]));
        end
      end else if (bus.o_valid) begin
        held    = {bus.o_last, bus.o_addr};
        holding = 1'b1;
      end
    end
  end

  initial begin : stim
    logic [63:0] nb;
    logic [63:0] sets [6];
    int sent;
    bus.i_valid = 1'b0;
    bus.i_nb    = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;

    tick();
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_o_addr", 32'(bus.o_addr), 32'(0));
    chk("rst_o_last", 32'(bus.o_last), 32'(0));
    chk("rst_o_ready", 32'(bus.o_ready), 32'(1));
    tick();

    // All equal neighbours, single-cycle valid with last set.
    send(pack8(100, 100, 100, 100, 100, 100, 100, 100), 1'b1, {1'b1, 8'hFF});
    latency3("lat_first");
    drain("drain_equal");

    send(pack8(0, 10, 20, 30, 40, 50, 60, 70), 1'b0, {1'b0, 8'hF0});
    send(pack8(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, {1'b0, 8'hFF});
`ifdef NI_MEAN_ROUND_EN
    send(pack8(1, 0, 0, 0, 0, 0, 0, 6), 1'b0, {1'b0, 8'h81});
`else
    send(pack8(1, 0, 0, 0, 0, 0, 0, 6), 1'b0, {1'b0, 8'hFF});
`endif
    send(pack8(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, {1'b0, 8'hFF});
    drain("drain_directed");

    // Six back-to-back sets, downstream stalls for five cycles once the first code appears.
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 8; k++) nb[k*8 +: 8] = (k == j) ? 8'd200 : 8'd10;
      sets[j] = nb;
    end
    sent = 0;
    for (int cyc = 0; cyc < 60 && (sent < 6 || q.size() > 0); cyc++) begin
      bus.i_ready = !(cyc >= 3 && cyc < 8);
      if (sent < 6) begin
        bus.i_valid = 1'b1;
        bus.i_nb    = sets[sent];
        bus.i_last  = (sent == 5);
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (cyc == 3) chk("stall_first_out", 32'(bus.o_valid), 32'(1));
      if (!bus.i_ready && bus.o_valid) chk("stall_o_ready", 32'(bus.o_ready), 32'(0));
      if (bus.i_valid && bus.o_ready) begin
        q.push_back({1'(sent == 5), 8'(1 << sent)});
        sent++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk("stall_sent", 32'(sent), 32'(6));
    drain("drain_stall");

    // Random valid/ready, 1000 pixels, last on the final one.
    rand_rdy = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      while ($urandom_range(0, 1) == 0) tick();
      for (int k = 0; k < 8; k++) begin
        if (p % 4 == 0) nb[k*8 +: 8] = 8'($urandom_range(96, 104));
        else            nb[k*8 +: 8] = 8'($urandom_range(0, 255));
      end
      send(nb, 1'(p == 999), model(nb, 1'(p == 999)));
    end
    drain("drain_random");
    rand_rdy    = 1'b0;
    bus.i_ready = 1'b1;
    tick();

    // Reset with three pixels in flight and the output held.
    for (int p = 0; p < 3; p++) begin
      nb = {$urandom, $urandom};
      send(nb, 1'b0, model(nb, 1'b0));
    end
    bus.i_ready = 1'b0;
    i_rst       = 1'b1;
    tick();
    i_rst       = 1'b0;
    bus.i_ready = 1'b1;
    q.delete();
    @(negedge i_clk);
    chk("mid_rst_o_valid", 32'(bus.o_valid), 32'(0));
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_idle", 32'(bus.o_valid), 32'(0));
    send(pack8(0, 10, 20, 30, 40, 50, 60, 70), 1'b1, {1'b1, 8'hF0});
    latency3("lat_after_rst");
    drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
